load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage of the RV32I core. Executes one load or store per request over a req/gnt/rvalid bus.
//  Loads: returns the sign- or zero-extended value to the writeback mux as its data-memory input (wb select 2'b01).
//  Stores: drives byte enables and lane-replicated write data.
//  Holds busy high so the control unit stalls the pipeline until done.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT before abort; used only when LSU_TIMEOUT_EN is defined
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   1-cycle request pulse from control; accepted only in IDLE
//  is_store    in   1   1=store, 0=load
//  funct3      in   3   RV32I width/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  addr        in   32  effective address from the ALU
//  wdata       in   32  store data (rs2)
//  busy        out  1   high in every state except IDLE
//  done        out  1   1-cycle pulse: access finished, load_data/err valid
//  err         out  1   valid with done: misaligned address or illegal funct3 (or timeout)
//  load_data   out  32  extended load result, held until the next done; 0 for stores/err
//  mem_req     out  1   bus request, held until mem_gnt
//  mem_we      out  1   write strobe, valid with mem_req
//  mem_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-replicated store data
//  mem_gnt     in   1   request accepted this cycle
//  mem_rvalid  in   1   response (rdata or write ack) valid this cycle
//  mem_rdata   in   32  read data
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including load_data. Asynchronous; takes effect mid-access.
//   A response arriving after reset is ignored.
//  On an accepted start: capture is_store, funct3, addr, wdata. All later outputs use the captured copies.
//  FSM:
//   IDLE -start & legal-> REQ;  IDLE -start & illegal-> RESP(err=1)
//   REQ  (mem_req=1) -mem_gnt-> WAIT
//   WAIT -mem_rvalid-> RESP; load_data captured from mem_rdata
//   RESP (done=1 for one cycle) -> IDLE
//  Illegal access: H with addr[0]!=0; W with addr[1:0]!=0; funct3 not valid for the op.
//   No bus request; err=1; load_data=0.
//  Latency, zero-wait bus: start@c0, mem_req@c1 with gnt@c1, rvalid@c2, done@c3.
//   Back-to-back start is accepted in the cycle after done.
//  start while busy is ignored. mem_gnt outside REQ and mem_rvalid outside WAIT are ignored.
//  mem_req, mem_addr, mem_we, mem_be, mem_wdata stay stable from REQ entry until gnt.
//  Store be: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111.
//  Store wdata: SB {4{b}}; SH {2{h}}; SW word.
//  Load extract: lane=addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
//  Stores also wait for mem_rvalid (write ack) before done.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   8-bit-min counter clears on REQ entry and increments each cycle in REQ/WAIT.
//   On reaching TIMEOUT_CYCLES: drop mem_req, go to RESP with err=1, load_data=0.
//  LSU_TIMEOUT_EN undefined: no counter; REQ/WAIT wait indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Shared package rv32i_pkg:
//   F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW constants
//   LSU state encodings (IDLE, REQ, WAIT, RESP)
//   wb select codes
//  Sub-module load_align: combinational lane select + extension (rdata, addr[1:0], funct3 -> 32-bit).
//   Instantiated once; FSM, capture regs and store lane logic stay in load_store_unit.
// TESTING
//  1 LW addr=0x100, gnt@c1, rvalid@c2 rdata=0xDEADBEEF -> mem_addr=0x100, be=1111; done@c3, load_data=0xDEADBEEF, err=0
//  2 LB addr=0x103, rdata=0x80FF0000 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF
//  3 SH addr=0x102 wdata=0x1234ABCD -> mem_we=1, mem_addr=0x100, be=1100, mem_wdata=0xABCDABCD; done after ack
//  4 LW addr=0x101 -> mem_req never asserts; done@c1, err=1, load_data=0; funct3=3'b011 load -> same
//  5 gnt withheld 5 cycles, extra start pulse at c2 -> bus outputs stable, start ignored, single done
//  6 rst_n low in WAIT -> outputs 0 immediately; later rvalid ignored.
//    With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no gnt -> done with err=1 after 8 cycles.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: funct3 codes, LSU state encoding, writeback select codes.
package rv32i_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Writeback mux select codes
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        LsuIdle = 2'b00,
        LsuReq  = 2'b01,
        LsuWait = 2'b10,
        LsuResp = 2'b11
    } lsu_state_e;

    // True when funct3 is valid for the operation and the address is naturally aligned.
    function automatic logic lsu_access_legal(input logic       is_store,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        logic legal;
        case (funct3)
            F3_LB:   legal = 1'b1;                    // also SB
            F3_LH:   legal = ~addr_lo[0];             // also SH
            F3_LW:   legal = (addr_lo == 2'b00);      // also SW
            F3_LBU:  legal = ~is_store;
            F3_LHU:  legal = ~is_store & ~addr_lo[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: selects the addressed byte/half lane of the read word and extends it.
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then sign/zero extension by funct3.
    always_comb begin
        byte_sel = rdata_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one load or store per start over a req/gnt/rvalid bus.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] aligned;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        in_req;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    load_align u_load_align (
        .rdata_i  (mem_rdata),
        .lane_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (aligned)
    );

    // Store byte enables and lane-replicated data from the captured request.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Next-state, capture and result logic.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        load_data_d = load_data_q;
`ifdef LSU_TIMEOUT_EN
        cnt_inc     = cnt_q + CntW'(1);
        cnt_d       = cnt_q;
`endif
        case (state_q)
            LsuIdle: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    if (lsu_access_legal(is_store, funct3, addr[1:0])) begin
                        state_d = LsuReq;
                        err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d     = LsuResp;
                        err_d       = 1'b1;
                        load_data_d = 32'd0;
                    end
                end
            end
            LsuReq: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (mem_gnt) begin
                    state_d = LsuWait;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                    state_d     = LsuResp;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
`endif
                end
            end
            LsuWait: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (mem_rvalid) begin
                    state_d     = LsuResp;
                    err_d       = 1'b0;
                    load_data_d = is_store_q ? 32'd0 : aligned;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                    state_d     = LsuResp;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
`endif
                end
            end
            default: state_d = LsuIdle;
        endcase
    end

    // State and capture registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LsuIdle;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            load_data_q <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Outputs decoded from state; bus fields are zero outside REQ.
    always_comb begin
        in_req    = (state_q == LsuReq);
        busy      = (state_q != LsuIdle);
        done      = (state_q == LsuResp);
        err       = done & err_q;
        load_data = load_data_q;
        mem_req   = in_req;
        mem_we    = in_req & is_store_q;
        mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be    = in_req ? be : 4'd0;
        mem_wdata = (in_req & is_store_q) ? wdata_rep : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized accesses
// checked against a byte-level reference model.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] held_ld = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (a % m_nbytes(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] f3);
        int unsigned nb = m_nbytes(f3);
        int unsigned lane = a % 4;
        logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
        logic [63:0] v = ({32'd0, rd} >> (8 * lane)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
        int unsigned nb = m_nbytes(f3);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] r;
        int unsigned nb = m_nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    // One complete access starting in the current cycle; ends in the idle cycle after done.
    task automatic run_access(input string name, input bit st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int gnt_wait, input int rv_wait,
                              input bit extra_start);
        bit          legal;
        logic [31:0] exp_ld;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        legal    = m_legal(st, f3, a);
        exp_ld   = (st || !legal) ? 32'd0 : m_load(rd, a, f3);
        exp_addr = {a[31:2], 2'b00};
        exp_be   = m_be(a, f3);
        exp_wd   = m_wdata(wd, f3);

        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle-before-start: busy=%b want 0", name, busy);
        end
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        cyc();
        start = 1'b0;
        is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;

        if (!legal) begin
            n_checks++;
            if (done !== 1'b1 || err !== 1'b1 || load_data !== 32'd0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s illegal-resp: done=%b err=%b ld=%h req=%b want 1 1 0 0",
                         name, done, err, load_data, mem_req);
            end
            held_ld = 32'd0;
        end else begin
            for (int i = 0; i <= gnt_wait; i++) begin
                n_checks++;
                if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== exp_addr ||
                    mem_be !== exp_be || (st && mem_wdata !== exp_wd) || done !== 1'b0 ||
                    busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s req[%0d]: req=%b we=%b addr=%h be=%b wd=%h done=%b want 1 %b %h %b %h 0",
                             name, i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, done,
                             st, exp_addr, exp_be, exp_wd);
                end
                start = extra_start && (i == 1);
                mem_rvalid = 1'($urandom);
                mem_gnt = (i == gnt_wait);
                cyc();
                start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            for (int i = 0; i <= rv_wait; i++) begin
                n_checks++;
                if (mem_req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wait[%0d]: req=%b busy=%b done=%b want 0 1 0",
                             name, i, mem_req, busy, done);
                end
                mem_gnt = 1'($urandom);
                mem_rvalid = (i == rv_wait);
                mem_rdata = (i == rv_wait) ? rd : $urandom;
                cyc();
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            n_checks++;
            if (done !== 1'b1 || err !== 1'b0 || load_data !== exp_ld) begin
                n_fail++;
                $display("FAIL %s resp: done=%b err=%b ld=%h want 1 0 %h",
                         name, done, err, load_data, exp_ld);
            end
            held_ld = exp_ld;
        end
        mem_rdata = $urandom;
        cyc();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || load_data !== held_ld) begin
            n_fail++;
            $display("FAIL %s after-done: done=%b busy=%b err=%b ld=%h want 0 0 0 %h",
                     name, done, busy, err, load_data, held_ld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || load_data !== 32'd0 ||
            mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 ||
            mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b err=%b ld=%h req=%b we=%b addr=%h be=%b wd=%h want all 0",
                     busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_directed();
        run_access("lw_0x100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        run_access("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
        run_access("lbu_0x103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
        run_access("lhu_0x102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
        run_access("sh_0x102", 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
        run_access("lw_misalign", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
        run_access("load_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
        run_access("sbu_illegal", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_stall_ignore_start();
        run_access("stall_lw", 1'b0, 3'b010, 32'h200, 32'h0, 32'h13579BDF, 5, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall idle[%0d]: busy=%b done=%b req=%b want 0 0 0",
                         i, busy, done, mem_req);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_access("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_reset_mid_access();
        run_access("pre_reset_lw", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h44;
        cyc();
        start = 1'b0; mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || load_data !== 32'd0 ||
            mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset-mid: busy=%b done=%b err=%b ld=%h req=%b want all 0",
                     busy, done, err, load_data, mem_req);
        end
        cyc();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        cyc();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || load_data !== 32'd0) begin
                n_fail++;
                $display("FAIL late-rvalid[%0d]: busy=%b done=%b ld=%h want 0 0 0",
                         i, busy, done, load_data);
            end
            cyc();
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        bit seen;
        cycles = 0;
        seen = 1'b0;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                cycles++;
                cyc();
            end
        end
        n_checks++;
        if (!seen || cycles !== int'(TO) || err !== 1'b1 || load_data !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout: seen=%b cycles=%0d err=%b ld=%h want 1 %0d 1 0",
                     seen, cycles, err, load_data, TO);
        end
        cyc();
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stall_ignore_start();
        test_random();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
